// File: rtl/cache_pkg.sv
// Shared widths, tag-block layout and FSM encoding for the direct-mapped cache.
package cache_pkg;
  localparam int ADDR_W    = 32;
  localparam int OFFSET_W  = 2;
  localparam int IDX_W     = 5;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
  localparam int TAG_MEM_W = TAG_W + 2;
  localparam int VALID_POS = 26;
  localparam int DIRTY_POS = 25;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_ALLOCATE  = 3'd4
  } state_e;

  function automatic logic [TAG_MEM_W-1:0] make_tag_block(
    input logic             valid,
    input logic             dirty,
    input logic [TAG_W-1:0] tag
  );
    return {valid, dirty, tag};
  endfunction
endpackage

// File: rtl/cache_data_memory.sv
// One-word-per-line data array: synchronous write, combinational read.
module cache_data_memory
  import cache_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [1 << IDX_W];

  // Line write; contents are qualified by the external valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller with external tag array.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 tag_we,
  output logic [IDX_W-1:0]     idx,
  output logic [ADDR_W-IDX_W-OFFSET_W+1:0] tag_block_in,
  input  logic [ADDR_W-IDX_W-OFFSET_W+1:0] tag_block_out
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
  localparam int TAG_MEM_W = TAG_W + 2;

  state_e                  state_r, state_s;
  logic [IDX_W-1:0]        sweep_r;
  logic [ADDR_W-1:OFFSET_W] addr_r;
  logic                    we_r;
  logic [DATA_W-1:0]       wdata_r;

  logic                    mem_req_r, mem_req_s;
  logic                    mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]       mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]       mem_wdata_r, mem_wdata_s;

  logic [TAG_W-1:0]        req_tag_s;
  logic [IDX_W-1:0]        req_idx_s;
  logic [TAG_W-1:0]        old_tag_s;
  logic                    blk_valid_s, blk_dirty_s, hit_s, ack_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    tag_we_s;
  logic [TAG_MEM_W-1:0]    tag_blk_s;
  logic                    dm_we_s;
  logic [DATA_W-1:0]       dm_wdata_s, dm_rdata_s;
  logic                    cpu_ready_s;
  logic [DATA_W-1:0]       cpu_rdata_s;
  logic                    unused_s;

  assign unused_s    = ^cpu_addr[OFFSET_W-1:0];
  assign req_tag_s   = addr_r[ADDR_W-1:IDX_W+OFFSET_W];
  assign req_idx_s   = addr_r[IDX_W+OFFSET_W-1:OFFSET_W];
  assign old_tag_s   = tag_block_out[TAG_W-1:0];
  assign blk_valid_s = tag_block_out[VALID_POS];
  assign blk_dirty_s = tag_block_out[DIRTY_POS];
  assign hit_s       = blk_valid_s && (old_tag_s == req_tag_s);
  // An ack only counts while a request is actually on the bus.
  assign ack_s       = mem_ack && mem_req_r;

  cache_data_memory #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_data (
    .clk   (iCLK),
    .we    (dm_we_s),
    .addr  (idx_s),
    .wdata (dm_wdata_s),
    .rdata (dm_rdata_s)
  );

  // Next-state, tag/data write strobes and CPU response.
  always_comb begin
    state_s     = state_r;
    idx_s       = req_idx_s;
    tag_we_s    = 1'b0;
    tag_blk_s   = {TAG_MEM_W{1'b0}};
    dm_we_s     = 1'b0;
    dm_wdata_s  = wdata_r;
    cpu_ready_s = 1'b0;
    cpu_rdata_s = {DATA_W{1'b0}};
    case (state_r)
      ST_INIT: begin
        idx_s    = sweep_r;
        tag_we_s = 1'b1;
        if (sweep_r == {IDX_W{1'b1}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (cpu_req) begin
          state_s = ST_COMPARE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (hit_s) begin
          cpu_ready_s = 1'b1;
          state_s     = ST_IDLE;
          if (we_r) begin
            dm_we_s   = 1'b1;
            tag_we_s  = 1'b1;
            tag_blk_s = make_tag_block(1'b1, 1'b1, req_tag_s);
          end else begin
            cpu_rdata_s = dm_rdata_s;
          end
        end else if (blk_valid_s && blk_dirty_s) begin
          state_s = ST_WRITEBACK;
        end else begin
          state_s = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        if (ack_s) begin
          state_s = ST_ALLOCATE;
        end else begin
          state_s = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        if (ack_s) begin
          dm_we_s    = 1'b1;
          dm_wdata_s = mem_rdata;
          tag_we_s   = 1'b1;
          tag_blk_s  = make_tag_block(1'b1, 1'b0, req_tag_s);
          state_s    = ST_COMPARE;
        end else begin
          state_s = ST_ALLOCATE;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Memory-side request for the next cycle; cleared for one cycle after every ack.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (ack_s) begin
      mem_req_s = 1'b0;
    end else if (state_s == ST_WRITEBACK) begin
      mem_req_s   = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = {old_tag_s, req_idx_s, {OFFSET_W{1'b0}}};
      mem_wdata_s = dm_rdata_s;
    end else if (state_s == ST_ALLOCATE) begin
      mem_req_s  = 1'b1;
      mem_addr_s = {req_tag_s, req_idx_s, {OFFSET_W{1'b0}}};
    end else begin
      mem_req_s = 1'b0;
    end
  end

  // State, INIT sweep counter and request latch.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_INIT;
      sweep_r <= {IDX_W{1'b0}};
      addr_r  <= {(ADDR_W-OFFSET_W){1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == ST_INIT) begin
        sweep_r <= sweep_r + IDX_W'(1);
      end
      if ((state_r == ST_IDLE) && cpu_req) begin
        addr_r  <= cpu_addr[ADDR_W-1:OFFSET_W];
        we_r    <= cpu_we;
        wdata_r <= cpu_wdata;
      end
    end
  end

  // Registered memory interface.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic retry_r;

  // Hit/miss counted only on the first COMPARE of each request.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      retry_r  <= 1'b0;
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if ((state_r == ST_ALLOCATE) && ack_s) begin
        retry_r <= 1'b1;
      end else if (state_r == ST_IDLE) begin
        retry_r <= 1'b0;
      end
      if ((state_r == ST_COMPARE) && !retry_r) begin
        if (hit_s) begin
          hit_cnt <= hit_cnt + 32'd1;
        end else begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

  // The tag strobe is forced low while reset is held so every output reads 0.
  assign tag_we       = tag_we_s & iRST_N;
  assign idx          = idx_s;
  assign tag_block_in = tag_blk_s;
  assign cpu_ready    = cpu_ready_s;
  assign cpu_rdata    = cpu_rdata_s;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a behavioural tag array.
`timescale 1ns/1ps
module tb_cache_controller;
  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        tag_we;
  logic [4:0]  idx;
  logic [26:0] tag_block_in, tag_block_out;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  logic [26:0] tag_mem [32];
  int tests = 0;
  int fails = 0;

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (tag_we) tag_mem[idx] <= tag_block_in;
  end
  assign tag_block_out = tag_mem[idx];

  cache_controller dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .tag_we(tag_we), .idx(idx), .tag_block_in(tag_block_in), .tag_block_out(tag_block_out)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 32; i++) begin
      chk("init_tag_we", {31'd0, tag_we}, 32'd1);
      chk("init_idx", {27'd0, idx}, i);
      chk("init_no_ready", {31'd0, cpu_ready}, 32'd0);
      step();
    end
    chk("init_done_tag_we", {31'd0, tag_we}, 32'd0);
  endtask

  initial begin
    iRST_N = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    step(); step();
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_tag_we", {31'd0, tag_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);

    // Read 0x40 held through INIT: clean miss and refill
    req(1'b0, 32'h0000_0040, 32'd0);
    iRST_N = 1'b1; #1;
    sweep_check();
    step();                                   // COMPARE (miss)
    chk("miss_no_ready", {31'd0, cpu_ready}, 32'd0);
    chk("miss_no_memreq_yet", {31'd0, mem_req}, 32'd0);
    step();                                   // ALLOCATE
    chk("alloc_req", {31'd0, mem_req}, 32'd1);
    chk("alloc_we", {31'd0, mem_we}, 32'd0);
    chk("alloc_addr", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("refill_tag_we", {31'd0, tag_we}, 32'd1);
    chk("refill_tag_blk", {5'd0, tag_block_in}, 32'h0400_0000);
    step(); mem_ack = 1'b0; #1;
    chk("refill_memreq_low", {31'd0, mem_req}, 32'd0);
    chk("refill_ready", {31'd0, cpu_ready}, 32'd1);
    chk("refill_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    step();
    chk("idle_ready_low", {31'd0, cpu_ready}, 32'd0);
    chk("idle_rdata_zero", cpu_rdata, 32'd0);

    // Read hit
    req(1'b0, 32'h0000_0040, 32'd0);
    step();
    chk("hit_ready", {31'd0, cpu_ready}, 32'd1);
    chk("hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("hit_no_memreq", {31'd0, mem_req}, 32'd0);
    cpu_req = 1'b0; step();

    // Write hit sets dirty
    req(1'b1, 32'h0000_0040, 32'h1234_5678);
    step();
    chk("wr_hit_ready", {31'd0, cpu_ready}, 32'd1);
    chk("wr_hit_tag_we", {31'd0, tag_we}, 32'd1);
    chk("wr_hit_idx", {27'd0, idx}, 32'd16);
    chk("wr_hit_tag_blk", {5'd0, tag_block_in}, 32'h0600_0000);
    cpu_req = 1'b0; step();

    // Read 0xC0: dirty miss, writeback with delayed ack, then refill
    req(1'b0, 32'h0000_00C0, 32'd0);
    step();                                   // COMPARE
    chk("dmiss_no_ready", {31'd0, cpu_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wb_req", {31'd0, mem_req}, 32'd1);
      chk("wb_we", {31'd0, mem_we}, 32'd1);
      chk("wb_addr", mem_addr, 32'h0000_0040);
      chk("wb_data", mem_wdata, 32'h1234_5678);
      chk("wb_no_ready", {31'd0, cpu_ready}, 32'd0);
    end
    mem_ack = 1'b1;
    step(); mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;  // stray ack while mem_req low
    chk("post_wb_req_low", {31'd0, mem_req}, 32'd0);
    step(); mem_ack = 1'b0; mem_rdata = 32'hCAFE_F00D;
    chk("alloc2_req", {31'd0, mem_req}, 32'd1);
    chk("alloc2_we", {31'd0, mem_we}, 32'd0);
    chk("alloc2_addr", mem_addr, 32'h0000_00C0);
    chk("alloc2_no_ready", {31'd0, cpu_ready}, 32'd0);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0; #1;
    chk("refill2_ready", {31'd0, cpu_ready}, 32'd1);
    chk("refill2_rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 1'b0; step();

    // Read hit then write hit on the new line
    req(1'b0, 32'h0000_00C0, 32'd0);
    step();
    chk("hit2_rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 1'b0; step();
    req(1'b1, 32'h0000_00C0, 32'hA5A5_A5A5);
    step();
    chk("wr_hit2_tag_blk", {5'd0, tag_block_in}, 32'h0600_0001);
    cpu_req = 1'b0; step();

    // Read 0x140 (same index, tag 2): reset during WRITEBACK
    req(1'b0, 32'h0000_0140, 32'd0);
    step(); step();
    chk("wb2_req", {31'd0, mem_req}, 32'd1);
    chk("wb2_addr", mem_addr, 32'h0000_00C0);
    chk("wb2_data", mem_wdata, 32'hA5A5_A5A5);
`ifdef CACHE_PERF_CNT_EN
    chk("perf_miss", miss_cnt, 32'd3);
    chk("perf_hit", hit_cnt, 32'd4);
`endif
    #2 iRST_N = 1'b0; #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_tag_we", {31'd0, tag_we}, 32'd0);
    cpu_req = 1'b0;
    step(); iRST_N = 1'b1; #1;
    sweep_check();

    // Old line must miss after the sweep
    req(1'b0, 32'h0000_00C0, 32'd0);
    step();
    chk("after_rst_miss", {31'd0, cpu_ready}, 32'd0);
    step();
    chk("after_rst_alloc_req", {31'd0, mem_req}, 32'd1);
    chk("after_rst_alloc_we", {31'd0, mem_we}, 32'd0);
    chk("after_rst_alloc_addr", mem_addr, 32'h0000_00C0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step(); mem_ack = 1'b0; #1;
    chk("after_rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("after_rst_rdata", cpu_rdata, 32'h1111_2222);
    cpu_req = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-back, write-allocate cache controller between the RV32I core's data port and main memory. Drives the external `cache_tag_memory` array through its `tag_we`/`idx`/`tag_block_in`/`tag_block_out` ports and owns the one-word-per-line data array. Serves hits in one cycle after acceptance. Resolves misses with an optional dirty writeback followed by a refill over a req/ack memory handshake.

## Interface
Parameters:
- `ADDR_W`, 32: CPU/memory address width.
- `OFFSET_W`, 2: byte offset bits; one 32-bit word per line.
- `IDX_W`, 5: index bits; 32 lines.
- `DATA_W`, 32: word width.
- `TAG_W` (local), `ADDR_W-IDX_W-OFFSET_W` = 25.
- `TAG_MEM_W` (local), `TAG_W+2` = 27.

Ports:
- `iCLK` in 1: single clock, rising edge.
- `iRST_N` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: request valid; held until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: byte address; low OFFSET_W bits are ignored.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data; valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = writeback, 0 = refill.
- `mem_addr` out ADDR_W: word-aligned memory address.
- `mem_wdata` out DATA_W: writeback data.
- `mem_rdata` in DATA_W: refill data; sampled when `mem_ack`=1.
- `mem_ack` in 1: memory completion; single-cycle.
- `tag_we` out 1: tag array write enable.
- `idx` out IDX_W: tag array index.
- `tag_block_in` out TAG_MEM_W: tag block to write, laid out as {valid[26], dirty[25], tag[24:0]}.
- `tag_block_out` in TAG_MEM_W: combinational tag read at `idx`.

## Operation
- Address split: tag = `addr[ADDR_W-1:IDX_W+OFFSET_W]`, index = `addr[IDX_W+OFFSET_W-1:OFFSET_W]`.
- FSM states: INIT, IDLE, COMPARE, WRITEBACK, ALLOCATE.
- **INIT** (entered on reset):
  - Sweeps `idx` 0..31 with `tag_we`=1 and `tag_block_in`=0, one line per cycle.
  - Moves to IDLE after line 31.
  - `cpu_req` is ignored during INIT.
- **IDLE**: when `cpu_req`=1, latch addr/we/wdata and go to COMPARE.
- **COMPARE**: `idx` = latched index. Hit = valid && tag match.
  - Read hit: `cpu_rdata` = data[idx], pulse `cpu_ready`, go to IDLE.
  - Write hit: data[idx] <= wdata; `tag_we`=1 with {1,1,tag}; pulse `cpu_ready`; go to IDLE.
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- **WRITEBACK**:
  - Drives `mem_req`=1, `mem_we`=1, `mem_addr`={old tag, idx, 2'b00}, `mem_wdata`=data[idx].
  - On `mem_ack`, go to ALLOCATE.
- **ALLOCATE**:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`={req tag, idx, 2'b00}.
  - On `mem_ack`: data[idx] <= `mem_rdata`; `tag_we` with {1,0,req tag}; go to COMPARE. The retry hits, and a write then sets dirty.
- Memory outputs and `cpu_rdata` are zero when not in use.
- `cpu_req` must stay asserted with stable fields until `cpu_ready`; a new request is accepted no earlier than the cycle after `cpu_ready`.

## Timing
- Reset values: all outputs 0. The state register resets to INIT with sweep counter 0.
- INIT lasts exactly 32 cycles after reset release.
- Hit latency: request accepted at edge N, `cpu_ready` high in cycle N+1.
- Clean miss: accept, then COMPARE, then ALLOCATE until ack, then COMPARE with `cpu_ready`. Total is 3 cycles plus memory wait.
- Dirty miss: adds the WRITEBACK cycles before ALLOCATE.
- `mem_req` and `mem_addr`/`mem_we`/`mem_wdata` are stable from assertion through the ack cycle. `mem_req` is low in the cycle after the ack.
- A `mem_ack` while `mem_req`=0 is ignored.
- Tag and data writes take effect at the rising edge on which `tag_we` (or the data write) is high.
- Reset asserted mid-operation: outputs drop to 0 asynchronously and the FSM returns to INIT. Any outstanding memory transaction is abandoned, and the memory side must tolerate this.

## Configuration
- `CACHE_PERF_CNT_EN` defined: adds 32-bit outputs `hit_cnt` and `miss_cnt`.
  - Each increments once per request, evaluated at its first COMPARE only (the retry after refill is not counted).
  - Both reset to 0 and wrap on overflow.
- Not defined: the ports and the counter logic are absent.

## Structure
- Shared package `cache_pkg`:
  - Width constants (ADDR_W, OFFSET_W, IDX_W, TAG_W, TAG_MEM_W).
  - Tag block bit positions (VALID_POS=26, DIRTY_POS=25).
  - State encoding typedef.
- Sub-module `cache_data_memory`: 32×DATA_W array with synchronous write and combinational read. It is instantiated inside the controller; the tag array stays external.

## Test plan
- Reset, then hold `cpu_req` -> no `cpu_ready` and `tag_we`=1 for exactly 32 cycles with `idx` 0..31; the first request is served after that.
- Read 0x0000_0040, memory acks with 0xDEADBEEF -> `mem_req`/`mem_we`=0 with `mem_addr`=0x40, then `cpu_rdata`=0xDEADBEEF; repeating the read -> `cpu_ready` one cycle after accept and no `mem_req`.
- Write 0x12345678 to 0x40 (hit) -> tag written as {1,1,0}; then read 0x0000_00C0 (same index 16, tag 1) -> writeback to 0x40 with data 0x12345678, then refill from 0xC0.
- Memory ack delayed 5 cycles -> `mem_req`/`mem_addr` stable throughout, `cpu_ready` only after the ack.
- Assert `iRST_N`=0 during WRITEBACK -> `mem_req`=0 immediately, INIT sweep restarts, and the old line reads as a miss afterwards.
- With `CACHE_PERF_CNT_EN`: 3 misses and 4 hits -> `miss_cnt`=3, `hit_cnt`=4.
